reg_sel_burst: RTL and testbench

//  Parametrised, registered successor of the regSel decoder. Decodes the output-enable and

---
 rtl/reg_sel_burst.sv | 169 ++++++++++++++++
 tb/tb_reg_sel_burst.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_sel_burst.sv
// Register-file OE/load select decoder with a mask-driven burst walker for push/pop microcode.
// Latency: every output is registered, 1 cycle from input sample to output.
// Backpressure: none; a burst advances only on burstStep and holds its outputs otherwise.
module reg_sel_burst #(
    parameter int NREGS = 8,
    parameter int SELW  = 3,
    parameter int NOPS  = 3
) (
    input  logic                 clock,
    input  logic                 notReset,
    input  logic                 opLatch,
    input  logic [NOPS*SELW-1:0] op,
    input  logic                 oe,
    input  logic                 load,
    input  logic [1:0]           oeSourceSel,
    input  logic                 loadSourceSel,
    input  logic [SELW-1:0]      useqRegSelOe,
    input  logic [SELW-1:0]      useqRegSelLoad,
    input  logic                 burstStart,
    input  logic [NREGS-1:0]     burstMask,
    input  logic                 burstMode,
    input  logic                 burstDir,
    input  logic                 burstStep,
    output logic [NREGS-1:0]     regOes,
    output logic [NREGS-1:0]     regNotLoads,
    output logic                 burstBusy,
    output logic                 burstDone,
    output logic                 selErr
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, WALK} state_t;

    state_t                 state;
    logic [NOPS*SELW-1:0]   op_reg;
    logic [NREGS-1:0]       mask;
    logic [SELW-1:0]        ptr;
    logic                   mode;
    logic                   dir;

    logic [SELW-1:0]        idx_oe;
    logic [SELW-1:0]        idx_ld;
    logic                   oe_src_ok;
    logic                   oe_in_range;
    logic                   ld_in_range;
    logic [NREGS-1:0]       dec_oes;
    logic [NREGS-1:0]       dec_nld;
    logic                   dec_err;

    logic [SELW-1:0]        start_ptr;
    logic [NREGS-1:0]       mask_rem;
    logic [SELW-1:0]        next_ptr;
    logic [NREGS-1:0]       start_oes;
    logic [NREGS-1:0]       start_nld;
    logic [NREGS-1:0]       next_oes;
    logic [NREGS-1:0]       next_nld;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [SELW-1:0] low_bit(input logic [NREGS-1:0] v);
        low_bit = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (v[i]) low_bit = SELW'(i);
        end
    endfunction

    // Index of the highest set bit (0 when the vector is empty).
    function automatic logic [SELW-1:0] high_bit(input logic [NREGS-1:0] v);
        high_bit = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (v[i]) high_bit = SELW'(i);
        end
    endfunction

    // Idle-mode decode: pick the OE/load index sources and expand to strobes.
    always_comb begin
        idx_oe    = '0;
        oe_src_ok = 1'b0;
        if (oeSourceSel == 2'd0) begin
            idx_oe    = useqRegSelOe;
            oe_src_ok = 1'b1;
        end else if (int'(oeSourceSel) <= NOPS) begin
            idx_oe    = op_reg[(int'(oeSourceSel) - 1) * SELW +: SELW];
            oe_src_ok = 1'b1;
        end
        idx_ld      = loadSourceSel ? op_reg[SELW-1:0] : useqRegSelLoad;
        oe_in_range = int'(idx_oe) < NREGS;
        ld_in_range = int'(idx_ld) < NREGS;
        dec_oes     = (oe && oe_src_ok && oe_in_range) ? (ONE << idx_oe) : '0;
        dec_nld     = (load && ld_in_range) ? ~(ONE << idx_ld) : '1;
        dec_err     = (oe && oe_src_ok && !oe_in_range) || (load && !ld_in_range);
    end

    // Burst pointer arithmetic: first register on start, next register on a step.
    always_comb begin
        start_ptr = burstDir ? high_bit(burstMask) : low_bit(burstMask);
        mask_rem  = mask & ~(ONE << ptr);
        next_ptr  = dir ? high_bit(mask_rem) : low_bit(mask_rem);
        start_oes = burstMode ? '0 : (ONE << start_ptr);
        start_nld = burstMode ? ~(ONE << start_ptr) : '1;
        next_oes  = mode ? '0 : (ONE << next_ptr);
        next_nld  = mode ? ~(ONE << next_ptr) : '1;
    end

    // Operand latch, burst FSM and all registered outputs.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state       <= IDLE;
            op_reg      <= '0;
            mask        <= '0;
            ptr         <= '0;
            mode        <= 1'b0;
            dir         <= 1'b0;
            regOes      <= '0;
            regNotLoads <= '1;
            burstBusy   <= 1'b0;
            burstDone   <= 1'b0;
            selErr      <= 1'b0;
        end else begin
            if (opLatch) op_reg <= op;
            case (state)
                IDLE: begin
                    if (burstStart && (|burstMask)) begin
                        state       <= WALK;
                        mask        <= burstMask;
                        mode        <= burstMode;
                        dir         <= burstDir;
                        ptr         <= start_ptr;
                        regOes      <= start_oes;
                        regNotLoads <= start_nld;
                        burstBusy   <= 1'b1;
                        burstDone   <= 1'b0;
                        selErr      <= 1'b0;
                    end else begin
                        // An empty-mask start completes at once.
                        regOes      <= dec_oes;
                        regNotLoads <= dec_nld;
                        selErr      <= dec_err;
                        burstBusy   <= 1'b0;
                        burstDone   <= burstStart;
                    end
                end
                WALK: begin
                    burstDone <= 1'b0;
                    if (burstStep) begin
                        if (|mask_rem) begin
                            mask        <= mask_rem;
                            ptr         <= next_ptr;
                            regOes      <= next_oes;
                            regNotLoads <= next_nld;
                        end else begin
                            // Last register consumed: the exit cycle shows the idle decode.
                            state       <= IDLE;
                            mask        <= '0;
                            ptr         <= '0;
                            regOes      <= dec_oes;
                            regNotLoads <= dec_nld;
                            selErr      <= dec_err;
                            burstBusy   <= 1'b0;
                            burstDone   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_sel_burst.sv
module tb_reg_sel_burst;

    typedef struct packed {
        logic [7:0] oes;
        logic [7:0] nld;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [5:0] oes;
        logic [5:0] nld;
        logic       busy;
        logic       done;
        logic       err;
    } exp6_t;

    logic       clock;
    logic       notReset;
    logic       opLatch;
    logic [8:0] op;
    logic       oe;
    logic       load;
    logic [1:0] oeSourceSel;
    logic       loadSourceSel;
    logic [2:0] useqRegSelOe;
    logic [2:0] useqRegSelLoad;
    logic       burstStart;
    logic [7:0] burstMask;
    logic       burstMode;
    logic       burstDir;
    logic       burstStep;
    logic [7:0] regOes;
    logic [7:0] regNotLoads;
    logic       burstBusy;
    logic       burstDone;
    logic       selErr;
    logic [5:0] regOes6;
    logic [5:0] regNotLoads6;
    logic       burstBusy6;
    logic       burstDone6;
    logic       selErr6;

    exp_t  exp_q[$];
    exp6_t exp6_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    reg_sel_burst #(.NREGS(8), .SELW(3), .NOPS(3)) dut (
        .clock(clock), .notReset(notReset), .opLatch(opLatch), .op(op),
        .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOe(useqRegSelOe), .useqRegSelLoad(useqRegSelLoad),
        .burstStart(burstStart), .burstMask(burstMask), .burstMode(burstMode),
        .burstDir(burstDir), .burstStep(burstStep),
        .regOes(regOes), .regNotLoads(regNotLoads), .burstBusy(burstBusy),
        .burstDone(burstDone), .selErr(selErr)
    );

    reg_sel_burst #(.NREGS(6), .SELW(3), .NOPS(3)) dut6 (
        .clock(clock), .notReset(notReset), .opLatch(opLatch), .op(op),
        .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOe(useqRegSelOe), .useqRegSelLoad(useqRegSelLoad),
        .burstStart(burstStart), .burstMask(burstMask[5:0]), .burstMode(burstMode),
        .burstDir(burstDir), .burstStep(burstStep),
        .regOes(regOes6), .regNotLoads(regNotLoads6), .burstBusy(burstBusy6),
        .burstDone(burstDone6), .selErr(selErr6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        opLatch = 0; op = '0; oe = 0; load = 0; oeSourceSel = 0; loadSourceSel = 0;
        useqRegSelOe = 0; useqRegSelLoad = 0; burstStart = 0; burstMask = 0;
        burstMode = 0; burstDir = 0; burstStep = 0;
    endtask

    task automatic test_reset;
        exp_t e;
        exp_t got;
        notReset = 0;
        opLatch = 1; op = '1; oe = 1; load = 1; oeSourceSel = 2'b11; loadSourceSel = 1;
        useqRegSelOe = '1; useqRegSelLoad = '1; burstStart = 1; burstMask = '1;
        burstMode = 1; burstDir = 1; burstStep = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                idle_inputs();
                notReset = 1;
            end
            exp_q.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
    endtask

    // Row: {opLatch, oeSourceSel, oe, load, loadSourceSel, regOes, regNotLoads}
    task automatic test_decode;
        logic [21:0] tbl [7];
        logic [7:0]  eo, en;
        exp_t e;
        exp_t got;
        tbl = '{
            {1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h01, 8'hFF},  // same-edge latch: old opReg field 0 = 0
            {1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'h02, 8'hFF},
            {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h04, 8'hFF},
            {1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h08, 8'hFF},
            {1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'h80, 8'hFF},
            {1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h80, 8'hFD},
            {1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, 8'hDF}
        };
        idle_inputs();
        op = {3'd7, 3'd3, 3'd1};
        useqRegSelOe = 3'd2;
        useqRegSelLoad = 3'd5;
        for (int i = 0; i < 7; i++) begin
            {opLatch, oeSourceSel, oe, load, loadSourceSel, eo, en} = tbl[i];
            exp_q.push_back('{eo, en, 1'b0, 1'b0, 1'b0});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL decode[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
    endtask

    // Row: {burstStart, burstStep, regOes, regNotLoads, burstBusy, burstDone}
    task automatic test_burst_oe_up;
        logic [19:0] tbl [7];
        logic [7:0]  eo, en;
        logic        eb, ed;
        exp_t e;
        exp_t got;
        tbl = '{
            {1'b1, 1'b0, 8'h01, 8'hFF, 1'b1, 1'b0},
            {1'b0, 1'b0, 8'h01, 8'hFF, 1'b1, 1'b0},  // no step: hold
            {1'b0, 1'b1, 8'h04, 8'hFF, 1'b1, 1'b0},
            {1'b0, 1'b1, 8'h20, 8'hFF, 1'b1, 1'b0},
            {1'b0, 1'b1, 8'h80, 8'hFF, 1'b1, 1'b0},
            {1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1},
            {1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0}
        };
        idle_inputs();
        burstMask = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            {burstStart, burstStep, eo, en, eb, ed} = tbl[i];
            exp_q.push_back('{eo, en, eb, ed, 1'b0});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL walk_oe[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
    endtask

    task automatic test_burst_load_down;
        logic [19:0] tbl [5];
        logic [7:0]  eo, en;
        logic        eb, ed;
        exp_t e;
        exp_t got;
        tbl = '{
            {1'b1, 1'b1, 8'h00, 8'hEF, 1'b1, 1'b0},  // start with step in idle: start wins
            {1'b0, 1'b1, 8'h00, 8'hFD, 1'b1, 1'b0},
            {1'b0, 1'b1, 8'h04, 8'hDF, 1'b0, 1'b1},  // exit cycle shows idle decode
            {1'b0, 1'b0, 8'h04, 8'hDF, 1'b0, 1'b0},
            {1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0}
        };
        idle_inputs();
        oe = 1; load = 1; useqRegSelOe = 3'd2; useqRegSelLoad = 3'd5;
        burstMask = 8'h12; burstMode = 1; burstDir = 1;
        for (int i = 0; i < 5; i++) begin
            {burstStart, burstStep, eo, en, eb, ed} = tbl[i];
            if (i == 4) begin
                oe = 0;
                load = 0;
            end
            exp_q.push_back('{eo, en, eb, ed, 1'b0});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL walk_load[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
    endtask

    // Row: {burstStart, burstStep, burstMask, regOes, burstBusy, burstDone}
    task automatic test_empty_and_restart;
        logic [19:0] tbl [6];
        logic [7:0]  eo;
        logic        eb, ed;
        exp_t e;
        exp_t got;
        tbl = '{
            {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1},  // empty mask: done only
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0},
            {1'b1, 1'b0, 8'h06, 8'h02, 1'b1, 1'b0},
            {1'b1, 1'b0, 8'hFF, 8'h02, 1'b1, 1'b0},  // restart mid-walk ignored
            {1'b1, 1'b1, 8'hFF, 8'h04, 1'b1, 1'b0},
            {1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1}
        };
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            {burstStart, burstStep, burstMask, eo, eb, ed} = tbl[i];
            exp_q.push_back('{eo, 8'hFF, eb, ed, 1'b0});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL empty_restart[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
        burstStep = 0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        exp_t e;
        exp_t got;
        idle_inputs();
        burstMask = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin burstStart = 1; exp_q.push_back('{8'h01, 8'hFF, 1'b1, 1'b0, 1'b0}); tick(); end
                1: begin burstStart = 0; burstStep = 1; exp_q.push_back('{8'h02, 8'hFF, 1'b1, 1'b0, 1'b0}); tick(); end
                2: begin notReset = 0; exp_q.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}); #1; end
                3: begin exp_q.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}); tick(); notReset = 1; end
                default: begin exp_q.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}); tick(); end
            endcase
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid_burst[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
        end
    endtask

    // Row: {oe, load, useqRegSelOe, useqRegSelLoad, main oes, main nld, nregs6 oes, nregs6 nld, nregs6 err}
    task automatic test_sel_err;
        logic [36:0] tbl [4];
        logic [7:0]  eo, en;
        logic [5:0]  eo6, en6;
        logic        ee6;
        exp_t  e;
        exp_t  got;
        exp6_t e6;
        exp6_t got6;
        tbl = '{
            {1'b1, 1'b0, 3'd7, 3'd0, 8'h80, 8'hFF, 6'h00, 6'h3F, 1'b1},
            {1'b1, 1'b0, 3'd5, 3'd0, 8'h20, 8'hFF, 6'h20, 6'h3F, 1'b0},
            {1'b0, 1'b0, 3'd7, 3'd0, 8'h00, 8'hFF, 6'h00, 6'h3F, 1'b0},
            {1'b0, 1'b1, 3'd7, 3'd6, 8'h00, 8'hBF, 6'h00, 6'h3F, 1'b1}
        };
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            {oe, load, useqRegSelOe, useqRegSelLoad, eo, en, eo6, en6, ee6} = tbl[i];
            exp_q.push_back('{eo, en, 1'b0, 1'b0, 1'b0});
            exp6_q.push_back('{eo6, en6, 1'b0, 1'b0, ee6});
            tick();
            e = exp_q.pop_front();
            got = {regOes, regNotLoads, burstBusy, burstDone, selErr};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL sel_err_n8[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got.oes, got.nld, got.busy, got.done, got.err, e.oes, e.nld, e.busy, e.done, e.err);
            end
            e6 = exp6_q.pop_front();
            got6 = {regOes6, regNotLoads6, burstBusy6, burstDone6, selErr6};
            vectors++;
            if (got6 !== e6) begin
                miscompares++;
                $display("FAIL sel_err_n6[%0d] actual oes=%h nld=%h busy/done/err=%b%b%b required oes=%h nld=%h busy/done/err=%b%b%b",
                         i, got6.oes, got6.nld, got6.busy, got6.done, got6.err, e6.oes, e6.nld, e6.busy, e6.done, e6.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_burst_oe_up();
        test_burst_load_down();
        test_empty_and_restart();
        test_reset_mid_burst();
        test_sel_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
